// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the round-robin 8:1 channel scheduler.
// Holds the FSM state encoding, the requester count and a one-hot helper.
package mux_sched_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = $clog2(NREQ);

  typedef logic [IDXW-1:0] idx_t;
  typedef logic [NREQ-1:0] vec_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic vec_t onehot(idx_t idx);
    vec_t v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Request/grant/data bundle between the requesters and the scheduler.
// The master side drives requests and payloads; the slave side is the scheduler.
interface mux_rr_scheduler_if;
  import mux_sched_pkg::*;

  vec_t req;
  vec_t data;
  vec_t gnt;
  idx_t sel;
  logic busy;
  logic y;

  modport master (output req, data, input gnt, sel, busy, y);
  modport slave  (input req, data, output gnt, sel, busy, y);

endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request after i_last_idx,
// searching upward and wrapping, so i_last_idx itself has lowest priority.
module rr_pick8
  import mux_sched_pkg::*;
(
  input  vec_t i_req,
  input  idx_t i_last_idx,
  output logic o_found,
  output idx_t o_idx
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise the tool infers a latch to hold it.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!o_found && i_req[idx_t'(int'(i_last_idx) + i)]) begin
        o_found = 1'b1;
        o_idx   = idx_t'(int'(i_last_idx) + i);
      end
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin burst scheduler for a shared 8:1 one-bit channel.
// An owner keeps the channel up to BURST_LEN cycles or until it drops req.
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input logic               clk,
  input logic               rst,
  mux_rr_scheduler_if.slave bus
);

  localparam int              CNTW     = 4;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BURST_LEN - 1);

  state_t          r_state, w_state_nxt;
  idx_t            r_sel, w_sel_nxt;
  idx_t            r_last, w_last_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  vec_t            r_gnt;
  logic            r_busy;
  logic            w_found;
  idx_t            w_pick;
  logic            w_burst_end;

  rr_pick8 u_pick (
    .i_req      (bus.req),
    .i_last_idx (r_last),
    .o_found    (w_found),
    .o_idx      (w_pick)
  );

  // The owner's own req is low on an early release, so the picker skips it
  // naturally; on a full burst it may win again when it is the sole requester.
  assign w_burst_end = (r_cnt == CNT_LAST) || !bus.req[r_sel];

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_pick;
          w_last_nxt  = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        if (!w_burst_end) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end else if (w_found) begin
          w_sel_nxt  = w_pick;
          w_last_nxt = w_pick;
          w_cnt_nxt  = '0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_last  <= idx_t'(NREQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == ST_GRANT);
      r_gnt   <= (w_state_nxt == ST_GRANT) ? onehot(w_sel_nxt) : '0;
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.sel  = r_sel;
  assign bus.busy = r_busy;
  assign bus.y    = r_busy & bus.data[r_sel];

endmodule
